el2_dccm_arb_ctrl: RTL

Two-requester arbiter and sequencer in front of the DCCM memory wrapper. It shares the single DCCM read/write port between the LSU (primary) and the DMA slave (secondary) and routes one-cycle-latency read data back to the requester that issued the read. A quiesce handshake drains the port for power or test-mode entry.

---
 rtl/el2_dccm_arb_ctrl.sv | 130 +++++++++++++
 1 files changed

// File: rtl/el2_dccm_arb_ctrl.sv
// DCCM port arbiter/sequencer: LSU-priority sharing with DMA, read-response routing, quiesce handshake.
// Optional anti-starvation for DMA is enabled by defining EL2_DCCM_ARB_STARVE_EN.
module el2_dccm_arb_ctrl #(
  parameter int DCCM_BITS        = 16,
  parameter int DCCM_FDATA_WIDTH = 39,
  parameter int STARVE_LIMIT     = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        lsu_req_valid,
  output logic                        lsu_req_ready,
  input  logic                        lsu_req_we,
  input  logic [DCCM_BITS-1:0]        lsu_req_addr,
  input  logic [DCCM_FDATA_WIDTH-1:0] lsu_req_wdata,
  output logic                        lsu_rsp_valid,
  output logic [DCCM_FDATA_WIDTH-1:0] lsu_rsp_rdata,
  input  logic                        dma_req_valid,
  output logic                        dma_req_ready,
  input  logic                        dma_req_we,
  input  logic [DCCM_BITS-1:0]        dma_req_addr,
  input  logic [DCCM_FDATA_WIDTH-1:0] dma_req_wdata,
  output logic                        dma_rsp_valid,
  output logic [DCCM_FDATA_WIDTH-1:0] dma_rsp_rdata,
  output logic                        dccm_wren,
  output logic                        dccm_rden,
  output logic [DCCM_BITS-1:0]        dccm_addr,
  output logic [DCCM_FDATA_WIDTH-1:0] dccm_wr_data,
  input  logic [DCCM_FDATA_WIDTH-1:0] dccm_rd_data,
  input  logic                        quiesce_req,
  output logic                        quiesce_ack
);

  typedef enum logic [1:0] {RUN, DRAIN, QUIESCED} state_t;

  state_t state;
  logic   run_ok;
  logic   lsu_grant;
  logic   dma_grant;
  logic   dma_force;
  logic   rd_grant;
  logic   tag_vld_p1;
  logic   tag_dma_p1;

  if (STARVE_LIMIT < 1 || STARVE_LIMIT > 15) begin : g_limit_chk
    $error("STARVE_LIMIT must be within 1..15");
  end

  // Grants only in RUN with no quiesce pending; reset masks every output immediately.
  assign run_ok    = !rst && (state == RUN) && !quiesce_req;
  assign lsu_grant = run_ok && lsu_req_valid && !dma_force;
  assign dma_grant = run_ok && dma_req_valid && (dma_force || !lsu_req_valid);
  assign rd_grant  = (lsu_grant && !lsu_req_we) || (dma_grant && !dma_req_we);

  assign lsu_req_ready = lsu_grant;
  assign dma_req_ready = dma_grant;

`ifdef EL2_DCCM_ARB_STARVE_EN
  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);
  logic [3:0] starve_cnt;

  assign dma_force = dma_req_valid && (starve_cnt == LIMIT);

  always_ff @(posedge clk) begin
    if (rst) begin
      starve_cnt <= '0;
    end else if (state == RUN) begin
      if (dma_grant || !dma_req_valid) begin
        starve_cnt <= '0;
      end else if (lsu_grant && (starve_cnt != LIMIT)) begin
        starve_cnt <= starve_cnt + 4'd1;
      end
    end
  end
`else
  assign dma_force = 1'b0;
`endif

  // Stage p0: issue the winner onto the memory port
  always_comb begin
    dccm_wren    = 1'b0;
    dccm_rden    = 1'b0;
    dccm_addr    = '0;
    dccm_wr_data = '0;
    if (lsu_grant) begin
      dccm_wren    = lsu_req_we;
      dccm_rden    = !lsu_req_we;
      dccm_addr    = lsu_req_addr;
      dccm_wr_data = lsu_req_wdata;
    end else if (dma_grant) begin
      dccm_wren    = dma_req_we;
      dccm_rden    = !dma_req_we;
      dccm_addr    = dma_req_addr;
      dccm_wr_data = dma_req_wdata;
    end
  end

  // Stage p1: read tag follows the memory's one-cycle read latency
  always_ff @(posedge clk) begin
    if (rst) begin
      tag_vld_p1 <= 1'b0;
      tag_dma_p1 <= 1'b0;
    end else begin
      tag_vld_p1 <= rd_grant;
      tag_dma_p1 <= dma_grant;
    end
  end

  assign lsu_rsp_valid = !rst && tag_vld_p1 && !tag_dma_p1;
  assign dma_rsp_valid = !rst && tag_vld_p1 && tag_dma_p1;
  assign lsu_rsp_rdata = lsu_rsp_valid ? dccm_rd_data : '0;
  assign dma_rsp_rdata = dma_rsp_valid ? dccm_rd_data : '0;

  // Ack falls in the same cycle quiesce_req is released.
  assign quiesce_ack = !rst && (state == QUIESCED) && quiesce_req;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RUN;
    end else begin
      case (state)
        RUN:      if (quiesce_req) state <= DRAIN;
        DRAIN:    if (!quiesce_req) state <= RUN;
                  else if (!tag_vld_p1) state <= QUIESCED;
        QUIESCED: if (!quiesce_req) state <= RUN;
        default:  state <= RUN;
      endcase
    end
  end

endmodule
